// File: rtl/egress_group_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// egress_group_scheduler_pkg
// Shared fabric definitions for the egress port-group scheduler: group size,
// free-space count type, scheduler state encoding and small index helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package egress_group_scheduler_pkg;

    // Number of 1G egress destinations sharing one crossbar channel.
    localparam int PORT_GROUP_SIZE    = 6;
    // Width of a per-port egress FIFO free-space count (64-bit words).
    localparam int EGRESS_SPACE_WIDTH = 10;

    typedef logic [EGRESS_SPACE_WIDTH-1:0] egress_space_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    // Width of an index into an n-entry port vector (at least one bit).
    function automatic int port_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Successor of idx in round-robin order over n entries.
    function automatic int wrap_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/egress_group_scheduler_if.sv
// -----------------------------------------------------------------------------
// egress_group_scheduler_if
// Request/grant bundle between the crossbar channel logic (master) and the
// egress group scheduler (slave).
//   dest_req      per-destination "a source is waiting"
//   port_link_up  per-destination egress link status
//   port_space    packed per-destination free words, port d at [d*SW +: SW]
//   fwd_start     channel accepted the offered grant (1-cycle pulse)
//   fwd_done      last word of the frame forwarded (1-cycle pulse)
//   grant_valid   destination offered (OFFER only)
//   grant_port    granted destination index
//   grant_onehot  one-hot form of grant_port
//   busy          frame in flight (ACTIVE)
//   timeout_err   watchdog forced a release (1-cycle pulse)
//   protocol_err  fwd_start/fwd_done seen in the wrong state (1-cycle pulse)
//   grant_count   frames completed via fwd_done, wraps at 2^32
// -----------------------------------------------------------------------------
interface egress_group_scheduler_if
    import egress_group_scheduler_pkg::*;
#(
    parameter int GROUP_SIZE  = PORT_GROUP_SIZE,
    parameter int SPACE_WIDTH = EGRESS_SPACE_WIDTH
);
    localparam int IDX_W = port_idx_width(GROUP_SIZE);

    logic [GROUP_SIZE-1:0]             dest_req;
    logic [GROUP_SIZE-1:0]             port_link_up;
    logic [GROUP_SIZE*SPACE_WIDTH-1:0] port_space;
    logic                              fwd_start;
    logic                              fwd_done;

    logic                              grant_valid;
    logic [IDX_W-1:0]                  grant_port;
    logic [GROUP_SIZE-1:0]             grant_onehot;
    logic                              busy;
    logic                              timeout_err;
    logic                              protocol_err;
    logic [31:0]                       grant_count;

    modport master (
        output dest_req, port_link_up, port_space, fwd_start, fwd_done,
        input  grant_valid, grant_port, grant_onehot, busy,
               timeout_err, protocol_err, grant_count
    );

    modport slave (
        input  dest_req, port_link_up, port_space, fwd_start, fwd_done,
        output grant_valid, grant_port, grant_onehot, busy,
               timeout_err, protocol_err, grant_count
    );

endinterface

// File: rtl/egress_group_scheduler_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// egress_group_scheduler_rr_priority_picker
// Combinational round-robin find-first: scans i_req starting at i_start,
// wrapping from N-1 to 0, and reports the first set bit. Generic enough to be
// reused for other round-robin arbiters (e.g. MAC lookup).
//   i_req    N-bit request vector
//   i_start  index where the scan begins (must be < N)
//   o_hit    any request set
//   o_idx    index of the first request found (0 when no hit)
// -----------------------------------------------------------------------------
module egress_group_scheduler_rr_priority_picker
    import egress_group_scheduler_pkg::*;
#(
    parameter int N     = PORT_GROUP_SIZE,
    parameter int IDX_W = port_idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    int w_cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path through
        // the block leaves it unassigned, which would otherwise infer a latch.
        o_hit  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = int'(i_start) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!o_hit && i_req[IDX_W'(w_cand)]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/egress_group_scheduler.sv
// -----------------------------------------------------------------------------
// egress_group_scheduler
// Shares one 64-bit crossbar channel across the 1G egress ports of a port
// group. Each idle cycle it offers the next eligible destination in
// round-robin order, holds the grant while the frame is forwarded, and
// releases it on fwd_done or when the stuck-frame watchdog expires.
//   clk    fabric clock
//   rst    asynchronous active-high reset
//   sched  request/grant bundle (slave side), see egress_group_scheduler_if
// -----------------------------------------------------------------------------
module egress_group_scheduler
    import egress_group_scheduler_pkg::*;
#(
    parameter int GROUP_SIZE     = PORT_GROUP_SIZE,
    parameter int SPACE_WIDTH    = EGRESS_SPACE_WIDTH,
    parameter int MIN_SPACE      = 192,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    egress_group_scheduler_if.slave   sched
);

    localparam int IDX_W = port_idx_width(GROUP_SIZE);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_OFFER   = OFFER;
    localparam logic [1:0] S_ACTIVE  = ACTIVE;
    localparam logic [1:0] S_RELEASE = RELEASE;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_grant_port;
    logic [WD_W-1:0]       r_watchdog;
    logic                  r_timeout_err;
    logic                  r_protocol_err;
    logic [31:0]           r_grant_count;

    logic [GROUP_SIZE-1:0] w_eligible;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_grant_eligible;
    logic                  w_stray;
    logic                  w_granted;

    // A destination is eligible only if its FIFO can take a max-size frame.
    always_comb begin
        w_eligible = '0;
        for (int d = 0; d < GROUP_SIZE; d++) begin
            w_eligible[d] = sched.dest_req[d] & sched.port_link_up[d] &
                (sched.port_space[d*SPACE_WIDTH +: SPACE_WIDTH] >= SPACE_WIDTH'(MIN_SPACE));
        end
    end

    egress_group_scheduler_rr_priority_picker #(
        .N     (GROUP_SIZE),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (w_eligible),
        .i_start (r_rr_ptr),
        .o_hit   (w_hit),
        .o_idx   (w_pick_idx)
    );

    assign w_grant_eligible = w_eligible[r_grant_port];

    // Handshake pulses that arrive in a state that cannot use them.
    assign w_stray = (sched.fwd_start && (r_state != S_OFFER)) ||
                     (sched.fwd_done  && (r_state != S_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_grant_port   <= '0;
            r_watchdog     <= '0;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
            r_grant_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_timeout_err  <= 1'b0;
            r_protocol_err <= w_stray;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_grant_port <= w_pick_idx;
                        r_state      <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // Start beats a simultaneous loss of eligibility.
                    if (sched.fwd_start) begin
                        r_watchdog <= '0;
                        r_state    <= S_ACTIVE;
                    end else if (!w_grant_eligible) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    // Eligibility is ignored here: the channel finishes the frame.
                    r_watchdog <= r_watchdog + 1'b1;
                    if (sched.fwd_done) begin
                        r_grant_count <= r_grant_count + 32'd1;
                        r_state       <= S_RELEASE;
                    end else if (r_watchdog == WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_rr_ptr <= IDX_W'(wrap_next(int'(r_grant_port), GROUP_SIZE));
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant outputs decode straight from state so an asynchronous reset
    // clears them immediately.
    assign w_granted          = (r_state == S_OFFER) || (r_state == S_ACTIVE);
    assign sched.grant_valid  = (r_state == S_OFFER);
    assign sched.grant_port   = w_granted ? r_grant_port : '0;
    assign sched.grant_onehot = w_granted ? (GROUP_SIZE'(1) << r_grant_port) : '0;
    assign sched.busy         = (r_state == S_ACTIVE);
    assign sched.timeout_err  = r_timeout_err;
    assign sched.protocol_err = r_protocol_err;
    assign sched.grant_count  = r_grant_count;

endmodule

// File: tb/tb_egress_group_scheduler.sv
// -----------------------------------------------------------------------------
// tb_egress_group_scheduler
// Directed bench for egress_group_scheduler: inputs change on the falling
// edge, outputs are compared on the falling edge against hand-derived values.
// -----------------------------------------------------------------------------
module tb_egress_group_scheduler;
    import egress_group_scheduler_pkg::*;

    localparam int GS  = 6;
    localparam int SW  = 10;
    localparam int MIN = 192;
    localparam int TO  = 4096;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    egress_group_scheduler_if #(.GROUP_SIZE(GS), .SPACE_WIDTH(SW)) sched_bus ();

    egress_group_scheduler #(
        .GROUP_SIZE     (GS),
        .SPACE_WIDTH    (SW),
        .MIN_SPACE      (MIN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sched_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_space(input int d, input int v);
        sched_bus.port_space[d*SW +: SW] = egress_space_t'(v);
    endtask

    task automatic reset_dut();
        sched_bus.dest_req  = '0;
        sched_bus.fwd_start = 1'b0;
        sched_bus.fwd_done  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Poll (bounded) for an offer, then check which port was offered.
    task automatic wait_grant(input int exp_port, input string tag);
        int n;
        n = 0;
        while (!sched_bus.grant_valid && n < 32) begin
            tick();
            n++;
        end
        check({tag, "_valid"},  32'(sched_bus.grant_valid), 32'd1);
        check({tag, "_port"},   32'(sched_bus.grant_port), 32'(exp_port));
        check({tag, "_onehot"}, 32'(sched_bus.grant_onehot), 32'(1 << exp_port));
    endtask

    // Accept the current offer and finish the frame len cycles later.
    task automatic run_frame(input int len);
        sched_bus.fwd_start = 1'b1;
        tick();
        sched_bus.fwd_start = 1'b0;
        check("frame_busy", 32'(sched_bus.busy), 32'd1);
        repeat (len - 2) tick();
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        sched_bus.dest_req     = '0;
        sched_bus.port_link_up = '1;
        sched_bus.fwd_start    = 1'b0;
        sched_bus.fwd_done     = 1'b0;
        for (int d = 0; d < GS; d++) set_space(d, 500);
        tick();
        tick();

        // Reset state
        check("rst_valid",  32'(sched_bus.grant_valid), 32'd0);
        check("rst_port",   32'(sched_bus.grant_port), 32'd0);
        check("rst_onehot", 32'(sched_bus.grant_onehot), 32'd0);
        check("rst_busy",   32'(sched_bus.busy), 32'd0);
        check("rst_tmo",    32'(sched_bus.timeout_err), 32'd0);
        check("rst_perr",   32'(sched_bus.protocol_err), 32'd0);
        check("rst_count",  sched_bus.grant_count, 32'd0);
        rst = 1'b0;
        tick();

        // Single request on port 2: offer one cycle later, 20-cycle frame
        sched_bus.dest_req = 6'b000100;
        tick();
        check("t1_valid",  32'(sched_bus.grant_valid), 32'd1);
        check("t1_port",   32'(sched_bus.grant_port), 32'd2);
        check("t1_onehot", 32'(sched_bus.grant_onehot), 32'h04);
        sched_bus.fwd_start = 1'b1;
        sched_bus.dest_req  = '0;
        tick();
        sched_bus.fwd_start = 1'b0;
        check("t1_busy",        32'(sched_bus.busy), 32'd1);
        check("t1_act_valid",   32'(sched_bus.grant_valid), 32'd0);
        check("t1_act_port",    32'(sched_bus.grant_port), 32'd2);
        check("t1_act_onehot",  32'(sched_bus.grant_onehot), 32'h04);
        repeat (19) tick();
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
        check("t1_rel_busy",   32'(sched_bus.busy), 32'd0);
        check("t1_rel_onehot", 32'(sched_bus.grant_onehot), 32'd0);
        check("t1_rel_tmo",    32'(sched_bus.timeout_err), 32'd0);
        check("t1_count",      sched_bus.grant_count, 32'd1);
        // Stray fwd_done while in RELEASE
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
        check("t1_perr",       32'(sched_bus.protocol_err), 32'd1);
        check("t1_perr_count", sched_bus.grant_count, 32'd1);
        tick();
        check("t1_perr_pulse", 32'(sched_bus.protocol_err), 32'd0);
        // rr_ptr is now 3: ports 0 and 3 requesting -> 3 wins
        sched_bus.dest_req = 6'b001001;
        wait_grant(3, "t1_rr");

        // All ports requesting, 10-cycle frames: 0,1,2,3,4,5,0
        reset_dut();
        sched_bus.dest_req = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            wait_grant(k % GS, "t2_grant");
            run_frame(10);
        end
        sched_bus.dest_req = '0;
        check("t2_count", sched_bus.grant_count, 32'd7);

        // Space threshold: 191 ineligible, 192 eligible
        reset_dut();
        set_space(1, 191);
        set_space(4, 192);
        sched_bus.dest_req = 6'b010010;
        wait_grant(4, "t3_first");
        set_space(1, 192);
        run_frame(10);
        wait_grant(1, "t3_second");
        run_frame(10);
        sched_bus.dest_req = '0;
        check("t3_count", sched_bus.grant_count, 32'd2);
        set_space(1, 500);
        set_space(4, 500);

        // Withdraw in OFFER, then start coinciding with eligibility loss
        reset_dut();
        sched_bus.dest_req = 6'b001000;
        wait_grant(3, "t4_offer");
        sched_bus.dest_req = '0;
        tick();
        check("t4_wd_valid",  32'(sched_bus.grant_valid), 32'd0);
        check("t4_wd_onehot", 32'(sched_bus.grant_onehot), 32'd0);
        check("t4_wd_port",   32'(sched_bus.grant_port), 32'd0);
        check("t4_wd_busy",   32'(sched_bus.busy), 32'd0);
        sched_bus.dest_req = 6'b001001;
        wait_grant(0, "t4_rr_kept");
        sched_bus.dest_req = '0;
        tick();
        sched_bus.dest_req = 6'b001000;
        wait_grant(3, "t4_offer2");
        sched_bus.dest_req  = '0;
        sched_bus.fwd_start = 1'b1;
        tick();
        sched_bus.fwd_start = 1'b0;
        check("t4_race_busy",  32'(sched_bus.busy), 32'd1);
        check("t4_race_valid", 32'(sched_bus.grant_valid), 32'd0);
        check("t4_race_port",  32'(sched_bus.grant_port), 32'd3);
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
        check("t4_count", sched_bus.grant_count, 32'd1);
        check("t4_perr",  32'(sched_bus.protocol_err), 32'd0);

        // Watchdog: no fwd_done -> timeout TO cycles after entering ACTIVE
        reset_dut();
        sched_bus.dest_req = 6'b000001;
        wait_grant(0, "t5_offer");
        sched_bus.fwd_start = 1'b1;
        sched_bus.dest_req  = '0;
        tick();
        sched_bus.fwd_start = 1'b0;
        repeat (TO - 1) tick();
        check("t5_pre_busy", 32'(sched_bus.busy), 32'd1);
        check("t5_pre_tmo",  32'(sched_bus.timeout_err), 32'd0);
        tick();
        check("t5_tmo",       32'(sched_bus.timeout_err), 32'd1);
        check("t5_tmo_busy",  32'(sched_bus.busy), 32'd0);
        check("t5_tmo_count", sched_bus.grant_count, 32'd0);
        tick();
        check("t5_tmo_pulse", 32'(sched_bus.timeout_err), 32'd0);
        // fwd_done on the terminal cycle wins over the watchdog
        sched_bus.dest_req = 6'b000001;
        wait_grant(0, "t5_offer2");
        sched_bus.fwd_start = 1'b1;
        sched_bus.dest_req  = '0;
        tick();
        sched_bus.fwd_start = 1'b0;
        repeat (TO - 1) tick();
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
        check("t5_done_tmo",   32'(sched_bus.timeout_err), 32'd0);
        check("t5_done_count", sched_bus.grant_count, 32'd1);
        check("t5_done_busy",  32'(sched_bus.busy), 32'd0);
        check("t5_done_perr",  32'(sched_bus.protocol_err), 32'd0);

        // Asynchronous reset mid-frame, then stray handshakes in IDLE
        sched_bus.dest_req = 6'b000100;
        wait_grant(2, "t6_offer");
        sched_bus.fwd_start = 1'b1;
        sched_bus.dest_req  = '0;
        tick();
        sched_bus.fwd_start = 1'b0;
        tick();
        check("t6_busy", 32'(sched_bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy",   32'(sched_bus.busy), 32'd0);
        check("t6_rst_valid",  32'(sched_bus.grant_valid), 32'd0);
        check("t6_rst_onehot", 32'(sched_bus.grant_onehot), 32'd0);
        check("t6_rst_port",   32'(sched_bus.grant_port), 32'd0);
        check("t6_rst_count",  sched_bus.grant_count, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_tmo", 32'(sched_bus.timeout_err), 32'd0);
        sched_bus.fwd_done = 1'b1;
        tick();
        sched_bus.fwd_done = 1'b0;
        check("t6_perr_done",  32'(sched_bus.protocol_err), 32'd1);
        check("t6_perr_count", sched_bus.grant_count, 32'd0);
        check("t6_perr_busy",  32'(sched_bus.busy), 32'd0);
        tick();
        check("t6_perr_pulse", 32'(sched_bus.protocol_err), 32'd0);
        sched_bus.fwd_start = 1'b1;
        tick();
        sched_bus.fwd_start = 1'b0;
        check("t6_perr_start", 32'(sched_bus.protocol_err), 32'd1);
        check("t6_start_busy", 32'(sched_bus.busy), 32'd0);
        tick();
        check("t6_perr_clear", 32'(sched_bus.protocol_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
